// File: rtl/vending_pkg.sv
// Shared types, coin values and the select-priority helper for the vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam int MAX_PRODUCTS = 8;

  localparam logic [2:0] NICKEL_V  = 3'd1;
  localparam logic [2:0] DIME_V    = 3'd2;
  localparam logic [2:0] QUARTER_V = 3'd5;

  // Isolates the lowest set bit; narrower request vectors are zero-extended by the caller.
  function automatic logic [MAX_PRODUCTS-1:0] lowest_one_hot(input logic [MAX_PRODUCTS-1:0] req);
    return req & (~req + 8'd1);
  endfunction

endpackage

// File: rtl/vending_ctrl_if.sv
// Front-end / driver-side signal bundle of the vending controller.
interface vending_ctrl_if #(
  parameter int NUM_PRODUCTS = 2,
  parameter int CW           = 4
);
  logic                    nickel;
  logic                    dime;
  logic                    quarter;
  logic [NUM_PRODUCTS-1:0] select;
  logic [NUM_PRODUCTS-1:0] sold_out;
  logic                    coin_return;
  logic [NUM_PRODUCTS-1:0] dispense;
  logic                    return_nickel;
  logic                    return_dime;
  logic                    reject_coin;
  logic [CW-1:0]           credit;
  logic [1:0]              state;

  modport master (
    output nickel, dime, quarter, select, sold_out, coin_return,
    input  dispense, return_nickel, return_dime, reject_coin, credit, state
  );

  modport slave (
    input  nickel, dime, quarter, select, sold_out, coin_return,
    output dispense, return_nickel, return_dime, reject_coin, credit, state
  );
endinterface

// File: rtl/vending_change_unit.sv
// Change payout sequencer: pays a loaded credit back one coin per cycle, dimes first, then a final nickel.
module vending_change_unit
  import vending_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] load,
  output logic          coin_dime,
  output logic          coin_nickel,
  output logic          done,
  output logic [CW-1:0] remaining
);
  localparam logic [CW-1:0] DIME_C   = CW'(DIME_V);
  localparam logic [CW-1:0] NICKEL_C = CW'(NICKEL_V);

  logic          busy_r;
  logic [CW-1:0] rem_r;

  // Coin paid this cycle and the credit left after it.
  always_comb begin
    coin_dime   = 1'b0;
    coin_nickel = 1'b0;
    remaining   = rem_r;
    if (busy_r && (rem_r >= DIME_C)) begin
      coin_dime = 1'b1;
      remaining = rem_r - DIME_C;
    end else if (busy_r && (rem_r == NICKEL_C)) begin
      coin_nickel = 1'b1;
      remaining   = rem_r - NICKEL_C;
    end else begin
      remaining = rem_r;
    end
  end

  assign done = busy_r && (remaining == {CW{1'b0}});

  // Load on start, then count down once per paid coin until empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      rem_r  <= {CW{1'b0}};
    end else if (start) begin
      busy_r <= 1'b1;
      rem_r  <= load;
    end else if (busy_r) begin
      busy_r <= !done;
      rem_r  <= remaining;
    end else begin
      busy_r <= 1'b0;
      rem_r  <= rem_r;
    end
  end
endmodule

// File: rtl/vending_ctrl.sv
// Vending controller: coin intake, product selection and change payout around a four-state FSM.
// Every interface output is driven straight from a register.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int NUM_PRODUCTS = 2,
  parameter int PRICE        = 4,
  parameter int MAX_CREDIT   = 10,
  parameter int CW           = 4
) (
  input  logic          clk,
  input  logic          reset,
  vending_ctrl_if.slave bus
);
  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW+2:0] SUM_MAX = (CW+3)'(MAX_CREDIT);

  state_t                  state_r, state_next_s;
  logic [CW-1:0]           credit_r, credit_next_s;
  logic [NUM_PRODUCTS-1:0] dispense_r, dispense_next_s;
  logic                    return_nickel_r, return_nickel_next_s;
  logic                    return_dime_r, return_dime_next_s;
  logic                    reject_coin_r, reject_coin_next_s;

  logic                    coin_any_s, coin_fits_s, vend_ok_s;
  logic [2:0]              coin_val_s;
  logic [CW+2:0]           sum_s;
  logic [MAX_PRODUCTS-1:0] elig_s, pick_s;
  logic                    chg_start_s, chg_dime_s, chg_nickel_s, chg_done_s;
  logic [CW-1:0]           chg_rem_s;

  // Highest-value coin wins; lower coins presented alongside it are dropped silently.
  always_comb begin
    if (bus.quarter)     coin_val_s = QUARTER_V;
    else if (bus.dime)   coin_val_s = DIME_V;
    else if (bus.nickel) coin_val_s = NICKEL_V;
    else                 coin_val_s = 3'd0;
  end

  assign coin_any_s  = bus.nickel | bus.dime | bus.quarter;
  assign sum_s       = {3'b000, credit_r} + {{CW{1'b0}}, coin_val_s};
  assign coin_fits_s = (sum_s <= SUM_MAX);

  // Sold-out products never compete for the vend slot.
  always_comb begin
    elig_s                   = {MAX_PRODUCTS{1'b0}};
    elig_s[NUM_PRODUCTS-1:0] = bus.select & ~bus.sold_out;
  end

  assign pick_s    = lowest_one_hot(elig_s);
  assign vend_ok_s = (state_r == CREDIT) && (credit_r >= PRICE_C) &&
                     (pick_s != {MAX_PRODUCTS{1'b0}});

  // Next-state logic; within CREDIT a valid vend outranks a refund request.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (coin_any_s && coin_fits_s) state_next_s = CREDIT;
        else                           state_next_s = IDLE;
      end
      CREDIT: begin
        if (vend_ok_s)            state_next_s = VEND;
        else if (bus.coin_return) state_next_s = CHANGE;
        else                      state_next_s = CREDIT;
      end
      VEND: begin
        if (credit_r != {CW{1'b0}}) state_next_s = CHANGE;
        else                        state_next_s = IDLE;
      end
      CHANGE: begin
        if (chg_done_s) state_next_s = IDLE;
        else            state_next_s = CHANGE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Next values of credit and the registered output pulses.
  always_comb begin
    credit_next_s        = credit_r;
    dispense_next_s      = {NUM_PRODUCTS{1'b0}};
    return_nickel_next_s = 1'b0;
    return_dime_next_s   = 1'b0;
    reject_coin_next_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (coin_any_s && coin_fits_s) credit_next_s = sum_s[CW-1:0];
        else                           reject_coin_next_s = coin_any_s;
      end
      CREDIT: begin
        if (vend_ok_s) begin
          credit_next_s      = credit_r - PRICE_C;
          dispense_next_s    = pick_s[NUM_PRODUCTS-1:0];
          reject_coin_next_s = coin_any_s;
        end else if (bus.coin_return) begin
          reject_coin_next_s = coin_any_s;
        end else if (coin_any_s && coin_fits_s) begin
          credit_next_s = sum_s[CW-1:0];
        end else begin
          reject_coin_next_s = coin_any_s;
        end
      end
      VEND: reject_coin_next_s = coin_any_s;
      CHANGE: begin
        reject_coin_next_s   = coin_any_s;
        return_dime_next_s   = chg_dime_s;
        return_nickel_next_s = chg_nickel_s;
        credit_next_s        = chg_rem_s;
      end
      default: credit_next_s = {CW{1'b0}};
    endcase
  end

  // The payout sequencer is loaded on the edge that enters CHANGE.
  assign chg_start_s = (state_next_s == CHANGE) && (state_r != CHANGE);

  vending_change_unit #(.CW(CW)) u_change (
    .clk         (clk),
    .reset       (reset),
    .start       (chg_start_s),
    .load        (credit_r),
    .coin_dime   (chg_dime_s),
    .coin_nickel (chg_nickel_s),
    .done        (chg_done_s),
    .remaining   (chg_rem_s)
  );

  // State and output registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      credit_r        <= {CW{1'b0}};
      dispense_r      <= {NUM_PRODUCTS{1'b0}};
      return_nickel_r <= 1'b0;
      return_dime_r   <= 1'b0;
      reject_coin_r   <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      credit_r        <= credit_next_s;
      dispense_r      <= dispense_next_s;
      return_nickel_r <= return_nickel_next_s;
      return_dime_r   <= return_dime_next_s;
      reject_coin_r   <= reject_coin_next_s;
    end
  end

  assign bus.state         = state_r;
  assign bus.credit        = credit_r;
  assign bus.dispense      = dispense_r;
  assign bus.return_nickel = return_nickel_r;
  assign bus.return_dime   = return_dime_r;
  assign bus.reject_coin   = reject_coin_r;
endmodule

// File: tb/tb_vending_ctrl.sv
// Self-checking bench for vending_ctrl: directed scenarios followed by random traffic,
// all compared cycle by cycle against a coin-counting reference model.
module tb_vending_ctrl;
  localparam int NP    = 2;
  localparam int PRICE = 4;
  localparam int MAXC  = 10;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic reset;

  vending_ctrl_if #(.NUM_PRODUCTS(NP), .CW(CW)) bus ();

  vending_ctrl #(
    .NUM_PRODUCTS(NP),
    .PRICE       (PRICE),
    .MAX_CREDIT  (MAXC),
    .CW          (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 holding credit, 2 vending, 3 paying out a planned coin list.
  int m_state  = 0;
  int m_credit = 0;
  int m_disp   = 0;
  bit m_rn     = 1'b0;
  bit m_rd     = 1'b0;
  bit m_rej    = 1'b0;
  int payout_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void plan_payout(input int amount);
    payout_q.delete();
    repeat (amount / 2) payout_q.push_back(2);
    if (amount % 2 == 1) payout_q.push_back(1);
  endfunction

  task automatic model_step(input bit n, input bit d, input bit q, input int sel,
                            input int so, input bit cr, input bit rst);
    int val;
    int elig;
    int coin;
    val    = q ? 5 : (d ? 2 : (n ? 1 : 0));
    m_disp = 0;
    m_rn   = 1'b0;
    m_rd   = 1'b0;
    m_rej  = 1'b0;
    if (rst) begin
      m_state  = 0;
      m_credit = 0;
      payout_q.delete();
    end else if (m_state == 2) begin
      m_rej = (val != 0);
      if (m_credit > 0) begin
        plan_payout(m_credit);
        m_state = 3;
      end else begin
        m_state = 0;
      end
    end else if (m_state == 3) begin
      m_rej = (val != 0);
      coin  = payout_q.pop_front();
      if (coin == 2) m_rd = 1'b1;
      else           m_rn = 1'b1;
      m_credit -= coin;
      if (payout_q.size() == 0) m_state = 0;
    end else begin
      elig = sel & ~so & ((1 << NP) - 1);
      if (m_state == 1 && m_credit >= PRICE && elig != 0) begin
        for (int i = 0; i < NP; i++) begin
          if (elig[i]) begin
            m_disp = 1 << i;
            break;
          end
        end
        m_credit -= PRICE;
        m_state   = 2;
        m_rej     = (val != 0);
      end else if (m_state == 1 && cr) begin
        plan_payout(m_credit);
        m_state = 3;
        m_rej   = (val != 0);
      end else if (val != 0 && m_credit + val <= MAXC) begin
        m_credit += val;
        m_state   = 1;
      end else begin
        m_rej = (val != 0);
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare just after it.
  task automatic step(input bit n, input bit d, input bit q, input int sel,
                      input int so, input bit cr, input bit rst);
    bus.nickel      = n;
    bus.dime        = d;
    bus.quarter     = q;
    bus.select      = sel[NP-1:0];
    bus.sold_out    = so[NP-1:0];
    bus.coin_return = cr;
    reset           = rst;
    @(posedge clk);
    model_step(n, d, q, sel, so, cr, rst);
    #1;
    check("state",      32'(bus.state),         m_state);
    check("credit",     32'(bus.credit),        m_credit);
    check("dispense",   32'(bus.dispense),      m_disp);
    check("ret_nickel", 32'(bus.return_nickel), int'(m_rn));
    check("ret_dime",   32'(bus.return_dime),   int'(m_rd));
    check("reject",     32'(bus.reject_coin),   int'(m_rej));
    check("credit_max", 32'(bus.credit <= 4'(MAXC)), 1);
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    int pulses;
    bit rn, rd, rq, rcr, rrst;
    int rsel, rso;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("rst_state", 32'(bus.state), 0);
    check("rst_credit", 32'(bus.credit), 0);

    // Quarter, dime, vend product 0, then dime + nickel change
    step(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    check("tp1_credit5", 32'(bus.credit), 5);
    step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    check("tp1_credit7", 32'(bus.credit), 7);
    step(1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0);
    check("tp1_dispense", 32'(bus.dispense), 1);
    check("tp1_credit3", 32'(bus.credit), 3);
    idle(1);
    check("tp1_in_change", 32'(bus.state), 3);
    idle(1);
    check("tp1_dime", 32'(bus.return_dime), 1);
    idle(1);
    check("tp1_nickel", 32'(bus.return_nickel), 1);
    check("tp1_idle", 32'(bus.state), 0);

    // Exact price, no change
    repeat (4) step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    check("tp2_credit4", 32'(bus.credit), 4);
    step(1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0);
    check("tp2_dispense", 32'(bus.dispense), 2);
    idle(1);
    check("tp2_idle", 32'(bus.state), 0);
    check("tp2_no_change", 32'({bus.return_dime, bus.return_nickel}), 0);

    // Overflow rejection, then full refund in dimes
    step(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    check("tp3_reject", 32'(bus.reject_coin), 1);
    check("tp3_credit10", 32'(bus.credit), 10);
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      pulses += int'(bus.return_dime);
    end
    check("tp3_dimes", 32'(pulses), 5);
    check("tp3_idle", 32'(bus.state), 0);

    // Sold-out handling and select contention
    step(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3, 3, 1'b0, 1'b0);
    check("tp4_all_soldout", 32'(bus.state), 1);
    step(1'b0, 1'b0, 1'b0, 3, 1, 1'b0, 1'b0);
    check("tp4_dispense", 32'(bus.dispense), 2);
    idle(3);

    // Vend, refund and coin in one cycle: vend wins, coin rejected
    step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0);
    check("tp5_reject", 32'(bus.reject_coin), 1);
    check("tp5_credit0", 32'(bus.credit), 0);
    check("tp5_vend", 32'(bus.state), 2);
    idle(1);
    check("tp5_idle", 32'(bus.state), 0);

    // Reset during the second CHANGE cycle abandons the payout
    step(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    idle(1);
    check("tp6_second_change", 32'(bus.state), 3);
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("tp6_credit0", 32'(bus.credit), 0);
    check("tp6_outputs0", 32'({bus.dispense, bus.return_dime, bus.return_nickel, bus.reject_coin}), 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      pulses += int'(bus.return_dime) + int'(bus.return_nickel);
    end
    check("tp6_no_more_pulses", 32'(pulses), 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rn   = ($urandom_range(0, 3) == 0);
      rd   = ($urandom_range(0, 3) == 0);
      rq   = ($urandom_range(0, 5) == 0);
      rsel = int'($urandom_range(0, 3));
      rso  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0;
      rcr  = ($urandom_range(0, 7) == 0);
      rrst = ($urandom_range(0, 99) == 0);
      step(rn, rd, rq, rsel, rso, rcr, rrst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vending_ctrl.md
Name: vending_ctrl

Overview:
- Parametrised multi-product vending controller; successor to the two-product, nickel/dime machine.
- Accepts nickels, dimes and quarters into a bounded credit register. Vends any of NUM_PRODUCTS items at a common price. Honours per-product sold-out flags.
- Pays change or refunds one coin per cycle (dimes first, then nickels).
- Sits between the coin-mech/keypad front end and the dispenser/coin-hopper drivers. All outputs are registered.

Parameters:
- NUM_PRODUCTS, 2: number of selectable products, 1..8.
- PRICE, 4: product price in nickel units (4 = $0.20), 1..MAX_CREDIT.
- MAX_CREDIT, 10: credit ceiling in nickel units (10 = $0.50); must be >= 5.
- CW, 4: credit register width; must satisfy 2**CW > MAX_CREDIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- nickel  in  1  nickel inserted this cycle (single-cycle pulse).
- dime  in  1  dime inserted this cycle.
- quarter  in  1  quarter inserted this cycle.
- select  in  NUM_PRODUCTS  product request, bit i = product i.
- sold_out  in  NUM_PRODUCTS  bit i high = product i empty.
- coin_return  in  1  refund request.
- dispense  out  NUM_PRODUCTS  one-hot, one-cycle vend pulse.
- return_nickel  out  1  eject one nickel this cycle.
- return_dime  out  1  eject one dime this cycle.
- reject_coin  out  1  inserted coin not accepted; pass it to the return chute.
- credit  out  CW  current credit in nickel units.
- state  out  2  FSM state: IDLE=0, CREDIT=1, VEND=2, CHANGE=3.

Behaviour:
- Reset (synchronous, wins over all inputs): state=IDLE, credit=0, dispense=0, return_nickel=0, return_dime=0, reject_coin=0. Reset mid-CHANGE discards the remaining credit; no further coins are ejected.
- Coin values: nickel=1, dime=2, quarter=5 units.
- Simultaneous coins: only the highest-value coin is considered. Lower-value coins that cycle are ignored (not credited, not rejected).
- Coin acceptance (IDLE or CREDIT): if credit+value <= MAX_CREDIT, credit updates on the same edge (visible next cycle). Otherwise credit is unchanged and reject_coin pulses for one cycle.
- Any coin arriving in VEND or CHANGE produces a reject_coin pulse.
- Select resolution: lowest-index bit set in (select & ~sold_out) wins. Select bits for sold-out products are ignored. A select with credit < PRICE is ignored.
- IDLE: an accepted coin moves to CREDIT. select and coin_return are ignored.
- CREDIT, priority order within one cycle:
  1. Valid select (credit >= PRICE and an eligible product): next state VEND, credit -= PRICE on that edge. Any coin that cycle is rejected; coin_return that cycle is ignored.
  2. Otherwise coin_return: next state CHANGE. Any coin that cycle is rejected.
  3. Otherwise coin acceptance as above; stay in CREDIT.
- VEND: lasts exactly one cycle; dispense[i] is high for that cycle. Select at edge n gives dispense high in cycle n+1. Next state is CHANGE if credit > 0, else IDLE.
- CHANGE: one coin per cycle.
  - credit >= 2: return_dime=1, credit -= 2.
  - credit == 1: return_nickel=1, credit=0.
  - Transition to IDLE on the edge where credit becomes 0.
  - return_dime and return_nickel are never high together.
  - Inputs other than reset are ignored, apart from coin rejection.
- Credit never exceeds MAX_CREDIT and never underflows. credit == 0 always holds in IDLE.

Decomposition:
- Package vending_pkg holds:
  - the state enum (IDLE, CREDIT, VEND, CHANGE);
  - coin value constants NICKEL_V=1, DIME_V=2, QUARTER_V=5;
  - a priority-select function returning a one-hot of the lowest set bit.
- One sub-module: vending_change_unit, the credit-to-coin payout sequencer. It takes a credit load and a start signal and emits one dime or nickel per cycle plus a done flag. The top FSM instantiates it.

Test Plan (PRICE=4, MAX_CREDIT=10, NUM_PRODUCTS=2):
- Quarter, then dime, then select=2'b01 -> credit 5, then 7; dispense=2'b01 for one cycle with credit 3. Then return_dime, then return_nickel on consecutive cycles; state returns to IDLE, credit 0.
- Exact price: nickel ×4 at credit 0, then select=2'b10 -> credit 4, one-cycle dispense=2'b10, no change pulses, IDLE next cycle.
- Overflow: quarter, quarter (credit 10), then nickel -> credit stays 10, reject_coin=1 for one cycle. Then coin_return -> five return_dime pulses, then IDLE.
- Sold out and contention: credit 5, sold_out=2'b01, select=2'b11 -> dispense=2'b10. With sold_out=2'b11, select is ignored and state stays CREDIT.
- Simultaneous events: credit 4 with select=2'b01, coin_return and dime all in the same cycle -> vend wins, reject_coin=1, credit 0, IDLE after VEND.
- Reset mid-payout: credit 10, coin_return, assert reset on the 2nd CHANGE cycle -> next cycle all outputs 0, credit 0, state IDLE, no further return pulses.
